// File: rtl/invaders_memory_map.sv
//------------------------------------------------------------------------------
// invaders_memory_map
//   CPU-side memory block for the arcade core: two program ROM banks, a colour
//   PROM and work RAM. The ROMs and colour PROM are loaded over the MiSTer
//   download port. A CLEAR/RUN/LOAD state machine zeroes the work RAM after
//   every load. Per-region additive checksums and a sticky download-error flag
//   are also maintained.
//
// Ports
//   Clock, Reset             : system clock, synchronous active-high reset
//   RW_n, Ram_Addr, Ram_in   : CPU work RAM write strobe (active low), address, data
//   Ram_out                  : work RAM read data, 1-cycle latency, 0 outside RUN
//   Addr, Rom_out, Rom_hit   : CPU ROM fetch address, read data and hit, 1-cycle latency
//   color_prom_addr/_out     : video read port of the colour PROM, 1-cycle latency
//   dn_download/addr/data/wr : HPS download interface
//   ready, busy              : RUN / (CLEAR or LOAD) status
//   dn_err                   : sticky, a download byte fell outside every region
//   rom0_sum/rom1_sum/cprom_sum : mod-256 sums of the bytes loaded per region
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module invaders_memory_map #(
   parameter int unsigned ROM0_AW       = 13,
   parameter logic [15:0] ROM0_DN_BASE  = 16'h0000,
   parameter logic [15:0] ROM0_CPU_BASE = 16'h0000,
   parameter int unsigned ROM1_AW       = 12,
   parameter logic [15:0] ROM1_DN_BASE  = 16'h2000,
   parameter logic [15:0] ROM1_CPU_BASE = 16'h5000,
   parameter int unsigned CPROM_AW      = 11,
   parameter logic [15:0] CPROM_DN_BASE = 16'h3000,
   parameter int unsigned RAM_AW        = 13
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                RW_n,
   input  logic [15:0]         Addr,
   output logic [7:0]          Rom_out,
   output logic                Rom_hit,
   input  logic [15:0]         Ram_Addr,
   input  logic [7:0]          Ram_in,
   output logic [7:0]          Ram_out,
   input  logic [CPROM_AW-1:0] color_prom_addr,
   output logic [7:0]          color_prom_out,
   input  logic                dn_download,
   input  logic [15:0]         dn_addr,
   input  logic [7:0]          dn_data,
   input  logic                dn_wr,
   output logic                ready,
   output logic                busy,
   output logic                dn_err,
   output logic [7:0]          rom0_sum,
   output logic [7:0]          rom1_sum,
   output logic [7:0]          cprom_sum
);

   typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

   state_t            state;
   logic [RAM_AW-1:0] clear_cnt;
   logic              dn_download_q;

   logic [7:0] rom0_mem  [2**ROM0_AW];
   logic [7:0] rom1_mem  [2**ROM1_AW];
   logic [7:0] cprom_mem [2**CPROM_AW];
   logic [7:0] ram_mem   [2**RAM_AW];

   logic [7:0] rom0_q, rom1_q, cprom_q, ram_q;
   logic       sel0_q, sel1_q;

   // Upper CPU RAM address bits are not decoded here.
   logic unused_ram_addr;
   assign unused_ram_addr = ^Ram_Addr[15:RAM_AW];

   //---------------------------------------------------------------------------
   // Download-side region decode, priority ROM0 > ROM1 > CPROM
   //---------------------------------------------------------------------------
   logic dn_m0, dn_m1, dn_mc;
   logic dn_hit0, dn_hit1, dn_hitc, dn_miss;
   logic load_start, dn_accept;

   assign dn_m0   = dn_addr[15:ROM0_AW]  == ROM0_DN_BASE[15:ROM0_AW];
   assign dn_m1   = dn_addr[15:ROM1_AW]  == ROM1_DN_BASE[15:ROM1_AW];
   assign dn_mc   = dn_addr[15:CPROM_AW] == CPROM_DN_BASE[15:CPROM_AW];
   assign dn_hit0 = dn_m0;
   assign dn_hit1 = dn_m1 & ~dn_m0;
   assign dn_hitc = dn_mc & ~dn_m0 & ~dn_m1;
   assign dn_miss = ~(dn_m0 | dn_m1 | dn_mc);

   // The cycle that enters LOAD already accepts a download byte, so the first
   // byte of a download is never lost to the edge detector.
   assign load_start = dn_download &
                       ((state == ST_CLEAR) | ((state == ST_RUN) & ~dn_download_q));
   assign dn_accept  = dn_wr & ~Reset & ((state == ST_LOAD) | load_start);

   //---------------------------------------------------------------------------
   // State machine, checksums and error flag
   //---------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state         <= ST_CLEAR;
         clear_cnt     <= '0;
         dn_download_q <= 1'b0;
         dn_err        <= 1'b0;
         rom0_sum      <= '0;
         rom1_sum      <= '0;
         cprom_sum     <= '0;
      end else begin
         dn_download_q <= dn_download;

         case (state)
            ST_CLEAR: begin
               if (dn_download) begin
                  state <= ST_LOAD;
               end else begin
                  clear_cnt <= clear_cnt + 1'b1;
                  if (clear_cnt == '1) state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (dn_download && !dn_download_q) state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (!dn_download) begin
                  state     <= ST_CLEAR;
                  clear_cnt <= '0;
               end
            end
            default: begin
               state     <= ST_CLEAR;
               clear_cnt <= '0;
            end
         endcase

         // A new download restarts the sums, folding in a byte that arrives
         // in the entry cycle.
         if (load_start) begin
            rom0_sum  <= (dn_accept && dn_hit0) ? dn_data : '0;
            rom1_sum  <= (dn_accept && dn_hit1) ? dn_data : '0;
            cprom_sum <= (dn_accept && dn_hitc) ? dn_data : '0;
            dn_err    <= dn_accept & dn_miss;
         end else if (dn_accept) begin
            if (dn_hit0) rom0_sum  <= rom0_sum  + dn_data;
            if (dn_hit1) rom1_sum  <= rom1_sum  + dn_data;
            if (dn_hitc) cprom_sum <= cprom_sum + dn_data;
            if (dn_miss) dn_err    <= 1'b1;
         end
      end
   end

   assign ready = (state == ST_RUN);
   assign busy  = (state == ST_CLEAR) || (state == ST_LOAD);

   //---------------------------------------------------------------------------
   // ROM banks and colour PROM: download write port, registered read port
   //---------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (dn_accept && dn_hit0) rom0_mem[dn_addr[ROM0_AW-1:0]] <= dn_data;
      rom0_q <= rom0_mem[Addr[ROM0_AW-1:0]];
   end

   always_ff @(posedge Clock) begin
      if (dn_accept && dn_hit1) rom1_mem[dn_addr[ROM1_AW-1:0]] <= dn_data;
      rom1_q <= rom1_mem[Addr[ROM1_AW-1:0]];
   end

   always_ff @(posedge Clock) begin
      if (dn_accept && dn_hitc) cprom_mem[dn_addr[CPROM_AW-1:0]] <= dn_data;
      cprom_q <= cprom_mem[color_prom_addr];
   end

   assign color_prom_out = cprom_q;

   // The bank select is registered in the same cycle as the BRAM outputs, so
   // the mux after them never mixes one cycle's select with another's data.
   logic cpu_hit0, cpu_hit1;
   assign cpu_hit0 = Addr[15:ROM0_AW] == ROM0_CPU_BASE[15:ROM0_AW];
   assign cpu_hit1 = (Addr[15:ROM1_AW] == ROM1_CPU_BASE[15:ROM1_AW]) & ~cpu_hit0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sel0_q <= 1'b0;
         sel1_q <= 1'b0;
      end else begin
         sel0_q <= cpu_hit0;
         sel1_q <= cpu_hit1;
      end
   end

   always_comb begin
      Rom_out = '0;
      Rom_hit = 1'b0;
      if (state != ST_LOAD) begin
         if (sel0_q) begin
            Rom_out = rom0_q;
            Rom_hit = 1'b1;
         end else if (sel1_q) begin
            Rom_out = rom1_q;
            Rom_hit = 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Work RAM: single write port shared by the clear sweep and the CPU
   //---------------------------------------------------------------------------
   logic              ram_we;
   logic [RAM_AW-1:0] ram_wa;
   logic [7:0]        ram_wd;

   always_comb begin
      ram_we = 1'b0;
      ram_wa = Ram_Addr[RAM_AW-1:0];
      ram_wd = Ram_in;
      if (!Reset) begin
         if (state == ST_CLEAR && !dn_download) begin
            ram_we = 1'b1;
            ram_wa = clear_cnt;
            ram_wd = '0;
         end else if (state == ST_RUN && !RW_n) begin
            ram_we = 1'b1;
         end
      end
   end

   // Read and write in the same always_ff give read-before-write ordering.
   always_ff @(posedge Clock) begin
      if (ram_we) ram_mem[ram_wa] <= ram_wd;
      ram_q <= ram_mem[Ram_Addr[RAM_AW-1:0]];
   end

   assign Ram_out = (state == ST_RUN) ? ram_q : '0;

endmodule

// File: tb/tb_invaders_memory_map.sv
//------------------------------------------------------------------------------
// tb_invaders_memory_map
//   Self-checking bench for invaders_memory_map. Randomised stimulus is
//   compared against a reference model that works on address ranges and plain
//   arrays.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_invaders_memory_map;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        RW_n;
   logic [15:0] Addr;
   logic [7:0]  Rom_out;
   logic        Rom_hit;
   logic [15:0] Ram_Addr;
   logic [7:0]  Ram_in;
   logic [7:0]  Ram_out;
   logic [10:0] color_prom_addr;
   logic [7:0]  color_prom_out;
   logic        dn_download;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic        ready;
   logic        busy;
   logic        dn_err;
   logic [7:0]  rom0_sum;
   logic [7:0]  rom1_sum;
   logic [7:0]  cprom_sum;

   always #5 Clock = ~Clock;

   invaders_memory_map dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .RW_n            (RW_n),
      .Addr            (Addr),
      .Rom_out         (Rom_out),
      .Rom_hit         (Rom_hit),
      .Ram_Addr        (Ram_Addr),
      .Ram_in          (Ram_in),
      .Ram_out         (Ram_out),
      .color_prom_addr (color_prom_addr),
      .color_prom_out  (color_prom_out),
      .dn_download     (dn_download),
      .dn_addr         (dn_addr),
      .dn_data         (dn_data),
      .dn_wr           (dn_wr),
      .ready           (ready),
      .busy            (busy),
      .dn_err          (dn_err),
      .rom0_sum        (rom0_sum),
      .rom1_sum        (rom1_sum),
      .cprom_sum       (cprom_sum)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model
   // Download map: 0000-1FFF ROM0, 2000-2FFF ROM1, 3000-37FF colour PROM.
   // CPU map: 0000-1FFF ROM0, 5000-5FFF ROM1.
   //---------------------------------------------------------------------------
   logic [7:0]  m_rom0  [8192];
   logic [7:0]  m_rom1  [4096];
   logic [7:0]  m_cprom [2048];
   logic [7:0]  m_ram   [8192];
   logic [7:0]  m_s0, m_s1, m_sc;
   bit          m_err;
   bit          m_loading;
   logic [15:0] wq [$];

   function automatic void model_dn(input logic [15:0] a, input logic [7:0] d);
      int unsigned ai = a;
      if (!m_loading) return;
      if (ai < 'h2000) begin
         m_rom0[ai] = d;
         m_s0 = m_s0 + d;
      end else if (ai < 'h3000) begin
         m_rom1[ai - 'h2000] = d;
         m_s1 = m_s1 + d;
      end else if (ai < 'h3800) begin
         m_cprom[ai - 'h3000] = d;
         m_sc = m_sc + d;
      end else begin
         m_err = 1'b1;
      end
   endfunction

   function automatic logic [8:0] model_rom(input logic [15:0] a);
      int unsigned ai = a;
      if (ai < 'h2000) return {1'b1, m_rom0[ai]};
      if (ai >= 'h5000 && ai < 'h6000) return {1'b1, m_rom1[ai - 'h5000]};
      return 9'h000;
   endfunction

   function automatic void model_ram_cleared();
      foreach (m_ram[i]) m_ram[i] = 8'h00;
   endfunction

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic dn_start(input bit with_wr, input logic [15:0] a, input logic [7:0] d);
      dn_download = 1'b1;
      dn_wr       = with_wr;
      dn_addr     = a;
      dn_data     = d;
      m_loading   = 1'b1;
      m_s0 = 8'h00; m_s1 = 8'h00; m_sc = 8'h00; m_err = 1'b0;
      if (with_wr) begin
         model_dn(a, d);
         wq.push_back(a);
      end
      tick();
      dn_wr = 1'b0;
   endtask

   task automatic dn_byte(input logic [15:0] a, input logic [7:0] d);
      dn_wr   = 1'b1;
      dn_addr = a;
      dn_data = d;
      model_dn(a, d);
      wq.push_back(a);
      tick();
      dn_wr = 1'b0;
   endtask

   task automatic dn_end();
      dn_download = 1'b0;
      tick();
      m_loading = 1'b0;
   endtask

   // CPU writes are thrown at the RAM while it clears; none may survive.
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 20000) begin
         RW_n     = 1'($urandom_range(0, 1));
         Ram_Addr = 16'($urandom);
         Ram_in   = 8'($urandom_range(1, 255));
         tick();
         n++;
      end
      RW_n = 1'b1;
      model_ram_cleared();
   endtask

   task automatic check_sums(input string tag);
      check({tag, "_rom0_sum"},  {24'h0, rom0_sum},  {24'h0, m_s0});
      check({tag, "_rom1_sum"},  {24'h0, rom1_sum},  {24'h0, m_s1});
      check({tag, "_cprom_sum"}, {24'h0, cprom_sum}, {24'h0, m_sc});
      check({tag, "_dn_err"},    {31'h0, dn_err},    {31'h0, m_err});
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   //---------------------------------------------------------------------------
   // Test sequence
   //---------------------------------------------------------------------------
   initial begin
      int          n;
      logic [8:0]  er;
      logic [7:0]  exp_ram, exp_cp;
      logic [15:0] a;

      Reset = 1'b1; RW_n = 1'b1; Addr = '0; Ram_Addr = '0; Ram_in = '0;
      color_prom_addr = '0; dn_download = 1'b0; dn_addr = '0; dn_data = '0; dn_wr = 1'b0;
      m_loading = 1'b0; m_s0 = 8'h00; m_s1 = 8'h00; m_sc = 8'h00; m_err = 1'b0;
      model_ram_cleared();

      repeat (3) tick();
      check("rst_ready",   {31'h0, ready},   0);
      check("rst_busy",    {31'h0, busy},    1);
      check("rst_rom_out", {24'h0, Rom_out}, 0);
      check("rst_rom_hit", {31'h0, Rom_hit}, 0);
      check_sums("rst");

      // Power-up clear, then every RAM location must read 00.
      Reset = 1'b0;
      wait_ready(n);
      check("clear_len_init", n, 8192);
      for (int unsigned i = 0; i < 8192; i++) begin
         Ram_Addr = 16'(i);
         tick();
         check("ram_init", {24'h0, Ram_out}, {24'h0, m_ram[i]});
      end

      // Fill every region with random data so all later reads are defined.
      dn_start(1'b1, 16'h0000, 8'($urandom));
      for (int unsigned i = 1; i < 'h3800; i++) dn_byte(16'(i), 8'($urandom));
      dn_end();
      check_sums("full_load");
      wait_ready(n);
      check("clear_len_full", n, 8192);

      // Small directed load.
      dn_start(1'b1, 16'h0000, 8'h01);
      dn_byte(16'h0001, 8'h02);
      dn_byte(16'h0002, 8'h03);
      dn_byte(16'h2000, 8'hFF);
      dn_end();
      check("dir_rom0_sum",  {24'h0, rom0_sum},  32'h06);
      check("dir_rom1_sum",  {24'h0, rom1_sum},  32'hFF);
      check("dir_cprom_sum", {24'h0, cprom_sum}, 32'h00);
      check("dir_dn_err",    {31'h0, dn_err},    0);
      check("dir_busy",      {31'h0, busy},      1);
      wait_ready(n);
      check("clear_len_dir", n, 8192);

      Addr = 16'h0001; tick();
      check("dir_rom_0001", {23'h0, Rom_hit, Rom_out}, {23'h0, 1'b1, 8'h02});
      Addr = 16'h5000; tick();
      check("dir_rom_5000", {23'h0, Rom_hit, Rom_out}, {23'h0, 1'b1, 8'hFF});
      Addr = 16'h4000; tick();
      check("dir_rom_4000", {23'h0, Rom_hit, Rom_out}, 32'h0);
      for (int i = 0; i < 8; i++) begin
         Addr = (i % 2 == 0) ? 16'h0000 : 16'h5000;
         tick();
         check("dir_rom_alt", {24'h0, Rom_out}, (i % 2 == 0) ? 32'h01 : 32'hFF);
      end

      // Random RUN traffic; download strobes without dn_download are ignored.
      for (int i = 0; i < 2000; i++) begin
         RW_n     = 1'($urandom_range(0, 1));
         Ram_Addr = 16'($urandom);
         Ram_in   = 8'($urandom);
         case ($urandom_range(0, 2))
            0:       Addr = 16'($urandom_range(0, 'h1FFF));
            1:       Addr = 16'($urandom_range('h5000, 'h5FFF));
            default: Addr = 16'($urandom);
         endcase
         color_prom_addr = 11'($urandom);
         dn_wr   = 1'($urandom_range(0, 1));
         dn_addr = 16'($urandom);
         dn_data = 8'($urandom);
         exp_ram = m_ram[Ram_Addr % 8192];
         er      = model_rom(Addr);
         exp_cp  = m_cprom[color_prom_addr];
         if (dn_wr) model_dn(dn_addr, dn_data);
         if (!RW_n) m_ram[Ram_Addr % 8192] = Ram_in;
         tick();
         check("run_ram",   {24'h0, Ram_out},          {24'h0, exp_ram});
         check("run_rom",   {23'h0, Rom_hit, Rom_out}, {23'h0, er});
         check("run_cprom", {24'h0, color_prom_out},   {24'h0, exp_cp});
      end
      dn_wr = 1'b0; RW_n = 1'b1;
      check_sums("run_idle");

      // Short load, then abandon its clear with a new download.
      dn_start(1'b1, 16'($urandom_range(0, 'h37FF)), 8'($urandom));
      dn_byte(16'($urandom_range(0, 'h37FF)), 8'($urandom));
      dn_end();
      repeat (100) tick();
      check("abandon_ready", {31'h0, ready}, 0);
      dn_start(1'b1, 16'($urandom_range(0, 'h37FF)), 8'($urandom));
      check("abandon_busy", {31'h0, busy}, 1);
      check_sums("abandon_start");

      Addr = 16'h0001; RW_n = 1'b0; Ram_Addr = 16'h0005; Ram_in = 8'hA5;
      dn_byte(16'h8000, 8'h55);
      check("load_dn_err",  {31'h0, dn_err},            1);
      check("load_rom",     {23'h0, Rom_hit, Rom_out},  0);
      check("load_ram_out", {24'h0, Ram_out},           0);
      for (int i = 0; i < 10; i++) dn_byte(16'($urandom_range(0, 'h37FF)), 8'($urandom));
      RW_n = 1'b1;
      dn_end();
      check("err_held_clear", {31'h0, dn_err}, 1);
      wait_ready(n);
      check("clear_len_abandon", n, 8192);
      check_sums("after_err_load");

      // Reset in the middle of a download.
      wq.delete();
      dn_start(1'b1, 16'($urandom_range(0, 'h37FF)), 8'($urandom));
      check("restart_err_clr", {31'h0, dn_err}, 0);
      for (int i = 0; i < 20; i++) dn_byte(16'($urandom_range(0, 'h37FF)), 8'($urandom));
      check_sums("mid_load");
      Reset = 1'b1;
      tick(); tick();
      dn_download = 1'b0;
      m_loading = 1'b0; m_s0 = 8'h00; m_s1 = 8'h00; m_sc = 8'h00; m_err = 1'b0;
      check_sums("mid_reset");
      check("mid_reset_busy",  {31'h0, busy},  1);
      check("mid_reset_ready", {31'h0, ready}, 0);
      Reset = 1'b0;
      wait_ready(n);
      check("clear_len_reset", n, 8192);
      foreach (wq[i]) begin
         a = wq[i];
         if (a < 16'h2000)      Addr = a;
         else if (a < 16'h3000) Addr = a - 16'h2000 + 16'h5000;
         else                   color_prom_addr = 11'(a - 16'h3000);
         er     = model_rom(Addr);
         exp_cp = m_cprom[color_prom_addr];
         tick();
         check("kept_rom",   {23'h0, Rom_hit, Rom_out}, {23'h0, er});
         check("kept_cprom", {24'h0, color_prom_out},   {24'h0, exp_cp});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
